// File: rtl/llc_set_writeback_pkg.sv
// Shared types for the LLC set writeback path: per-way field types, set/way indices
// and the writeback FSM state encoding.
package llc_set_writeback_pkg;

    localparam int LLC_WAYS  = 16;
    localparam int WAY_BITS  = 4;
    localparam int SET_BITS  = 9;
    localparam int LINE_BITS = 128;
    localparam int TAG_BITS  = 17;
    localparam int SHR_BITS  = 16;
    localparam int OWN_BITS  = 4;
    localparam int HPR_BITS  = 1;
    localparam int STA_BITS  = 3;

    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [TAG_BITS-1:0]  llc_tag_t;
    typedef logic [SHR_BITS-1:0]  sharers_t;
    typedef logic [OWN_BITS-1:0]  owner_t;
    typedef logic [HPR_BITS-1:0]  hprot_t;
    typedef logic [STA_BITS-1:0]  llc_state_t;
    typedef logic [WAY_BITS-1:0]  llc_way_t;
    typedef logic [SET_BITS-1:0]  llc_set_t;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WRITE = 2'd1,
        WB_EVICT = 2'd2,
        WB_DONE  = 2'd3
    } llc_wb_state_t;

endpackage

// File: rtl/llc_wb_next_way.sv
// Combinational priority encoder: lowest set mask bit strictly above idx_i.
// found_o is low when no such bit exists (idx_i was the last dirty way).
module llc_wb_next_way
    import llc_set_writeback_pkg::*;
(
    input  logic [LLC_WAYS-1:0] mask_i,
    input  llc_way_t            idx_i,
    output logic                found_o,
    output llc_way_t            next_o
);

    logic [LLC_WAYS-1:0] above_s;

    // Qualify each mask bit with its position relative to the current index
    always_comb begin
        above_s = '0;
        for (int i = 0; i < LLC_WAYS; i++) begin
            above_s[i] = mask_i[i] & (i > int'(idx_i));
        end
    end

    // Scan downwards so the lowest qualifying way is the last one written
    always_comb begin
        found_o = 1'b0;
        next_o  = '0;
        for (int i = LLC_WAYS - 1; i >= 0; i--) begin
            next_o  = above_s[i] ? llc_way_t'(i) : next_o;
            found_o = found_o | above_s[i];
        end
    end

endmodule

// File: rtl/llc_set_writeback.sv
// Drains a buffered LLC set back into the LLC arrays, one way per write beat.
// Build option: LLC_WB_SKIP_CLEAN_EN writes only ways flagged in the captured dirty mask.
module llc_set_writeback
    import llc_set_writeback_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_start_valid,
    output logic                wb_start_ready,
    input  llc_set_t            wb_set,
    input  logic [LLC_WAYS-1:0] wb_dirty_mask,
    input  logic                wb_evict_upd,
    input  llc_way_t            evict_way_buf,
    input  line_t               lines_buf      [LLC_WAYS],
    input  llc_tag_t            tags_buf       [LLC_WAYS],
    input  sharers_t            sharers_buf    [LLC_WAYS],
    input  owner_t              owners_buf     [LLC_WAYS],
    input  hprot_t              hprots_buf     [LLC_WAYS],
    input  logic                dirty_bits_buf [LLC_WAYS],
    input  llc_state_t          states_buf     [LLC_WAYS],
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic                wr_evict,
    output llc_set_t            wr_set,
    output llc_way_t            wr_way,
    output line_t               wr_data_line,
    output llc_tag_t            wr_data_tag,
    output sharers_t            wr_data_sharers,
    output owner_t              wr_data_owner,
    output hprot_t              wr_data_hprot,
    output logic                wr_data_dirty_bit,
    output llc_state_t          wr_data_state,
    output llc_way_t            wr_data_evict_way,
    output logic                wb_busy,
    output logic                wb_done
);

    llc_wb_state_t state_q, state_d;
    llc_set_t      set_q, set_d;
    logic          evict_upd_q, evict_upd_d;
    llc_way_t      evict_way_q, evict_way_d;
    llc_way_t      way_q, way_d;

    logic          first_found_s;
    llc_way_t      first_way_s;
    logic          last_way_s;
    llc_way_t      next_way_s;

`ifdef LLC_WB_SKIP_CLEAN_EN
    logic [LLC_WAYS-1:0] mask_q, mask_d;
    logic                first_above_found_s;
    llc_way_t            first_above_s;
    logic                next_found_s;

    llc_wb_next_way u_first_way (
        .mask_i  (wb_dirty_mask),
        .idx_i   ('0),
        .found_o (first_above_found_s),
        .next_o  (first_above_s)
    );

    llc_wb_next_way u_next_way (
        .mask_i  (mask_q),
        .idx_i   (way_q),
        .found_o (next_found_s),
        .next_o  (next_way_s)
    );

    // Way 0 is not "above" index 0, so it is tested separately for the first beat
    assign first_found_s = wb_dirty_mask[0] | first_above_found_s;
    assign first_way_s   = wb_dirty_mask[0] ? '0 : first_above_s;
    assign last_way_s    = ~next_found_s;
    assign mask_d        = (state_q == WB_IDLE && wb_start_valid) ? wb_dirty_mask : mask_q;

    // Dirty mask capture register
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end
`else
    logic unused_mask_s;

    assign unused_mask_s = ^wb_dirty_mask;
    assign first_found_s = 1'b1;
    assign first_way_s   = '0;
    assign next_way_s    = way_q + llc_way_t'(1);
    assign last_way_s    = (way_q == llc_way_t'(LLC_WAYS - 1));
`endif

    // FSM next state, start capture and way sequencing
    always_comb begin
        state_d     = state_q;
        set_d       = set_q;
        evict_upd_d = evict_upd_q;
        evict_way_d = evict_way_q;
        way_d       = way_q;
        case (state_q)
            WB_IDLE: begin
                if (wb_start_valid) begin
                    set_d       = wb_set;
                    evict_upd_d = wb_evict_upd;
                    evict_way_d = evict_way_buf;
                    way_d       = first_way_s;
                    if (first_found_s) begin
                        state_d = WB_WRITE;
                    end else if (wb_evict_upd) begin
                        state_d = WB_EVICT;
                    end else begin
                        state_d = WB_DONE;
                    end
                end else begin
                    state_d = WB_IDLE;
                end
            end
            WB_WRITE: begin
                if (wr_ready) begin
                    if (last_way_s) begin
                        state_d = evict_upd_q ? WB_EVICT : WB_DONE;
                    end else begin
                        way_d = next_way_s;
                    end
                end else begin
                    state_d = WB_WRITE;
                end
            end
            WB_EVICT: begin
                if (wr_ready) begin
                    state_d = WB_DONE;
                end else begin
                    state_d = WB_EVICT;
                end
            end
            WB_DONE: begin
                state_d = WB_IDLE;
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

    // State and capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WB_IDLE;
            set_q       <= '0;
            evict_upd_q <= 1'b0;
            evict_way_q <= '0;
            way_q       <= '0;
        end else begin
            state_q     <= state_d;
            set_q       <= set_d;
            evict_upd_q <= evict_upd_d;
            evict_way_q <= evict_way_d;
            way_q       <= way_d;
        end
    end

    // Output decode; everything except start_ready is zero outside WRITE/EVICT/DONE
    always_comb begin
        wb_start_ready    = 1'b0;
        wb_busy           = 1'b0;
        wb_done           = 1'b0;
        wr_valid          = 1'b0;
        wr_evict          = 1'b0;
        wr_set            = '0;
        wr_way            = '0;
        wr_data_line      = '0;
        wr_data_tag       = '0;
        wr_data_sharers   = '0;
        wr_data_owner     = '0;
        wr_data_hprot     = '0;
        wr_data_dirty_bit = 1'b0;
        wr_data_state     = '0;
        wr_data_evict_way = '0;
        case (state_q)
            WB_IDLE: begin
                wb_start_ready = 1'b1;
            end
            WB_WRITE: begin
                wb_busy           = 1'b1;
                wr_valid          = 1'b1;
                wr_set            = set_q;
                wr_way            = way_q;
                wr_data_line      = lines_buf[way_q];
                wr_data_tag       = tags_buf[way_q];
                wr_data_sharers   = sharers_buf[way_q];
                wr_data_owner     = owners_buf[way_q];
                wr_data_hprot     = hprots_buf[way_q];
                wr_data_dirty_bit = dirty_bits_buf[way_q];
                wr_data_state     = states_buf[way_q];
                wr_data_evict_way = evict_way_q;
            end
            WB_EVICT: begin
                wb_busy           = 1'b1;
                wr_valid          = 1'b1;
                wr_evict          = 1'b1;
                wr_set            = set_q;
                wr_data_evict_way = evict_way_q;
            end
            WB_DONE: begin
                wb_done = 1'b1;
            end
            default: begin
                wb_start_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_llc_set_writeback.sv
// Randomized self-checking bench for llc_set_writeback: a queue of expected beats is
// built from the mask/evict rules and compared cycle by cycle against the write port.
module tb_llc_set_writeback;
    import llc_set_writeback_pkg::*;

`ifdef LLC_WB_SKIP_CLEAN_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int PAT_LEN = 512;
    localparam int DATA_W  = LINE_BITS + TAG_BITS + SHR_BITS + OWN_BITS + HPR_BITS + 1 + STA_BITS;

    logic                clk = 1'b0;
    logic                rst;
    logic                wb_start_valid;
    logic                wb_start_ready;
    llc_set_t            wb_set;
    logic [LLC_WAYS-1:0] wb_dirty_mask;
    logic                wb_evict_upd;
    llc_way_t            evict_way_buf;
    line_t               lines_buf      [LLC_WAYS];
    llc_tag_t            tags_buf       [LLC_WAYS];
    sharers_t            sharers_buf    [LLC_WAYS];
    owner_t              owners_buf     [LLC_WAYS];
    hprot_t              hprots_buf     [LLC_WAYS];
    logic                dirty_bits_buf [LLC_WAYS];
    llc_state_t          states_buf     [LLC_WAYS];
    logic                wr_valid;
    logic                wr_ready;
    logic                wr_evict;
    llc_set_t            wr_set;
    llc_way_t            wr_way;
    line_t               wr_data_line;
    llc_tag_t            wr_data_tag;
    sharers_t            wr_data_sharers;
    owner_t              wr_data_owner;
    hprot_t              wr_data_hprot;
    logic                wr_data_dirty_bit;
    llc_state_t          wr_data_state;
    llc_way_t            wr_data_evict_way;
    logic                wb_busy;
    logic                wb_done;

    int checks   = 0;
    int failures = 0;
    bit ready_pat [PAT_LEN];

    always #5 clk = ~clk;

    llc_set_writeback dut (
        .clk               (clk),
        .rst               (rst),
        .wb_start_valid    (wb_start_valid),
        .wb_start_ready    (wb_start_ready),
        .wb_set            (wb_set),
        .wb_dirty_mask     (wb_dirty_mask),
        .wb_evict_upd      (wb_evict_upd),
        .evict_way_buf     (evict_way_buf),
        .lines_buf         (lines_buf),
        .tags_buf          (tags_buf),
        .sharers_buf       (sharers_buf),
        .owners_buf        (owners_buf),
        .hprots_buf        (hprots_buf),
        .dirty_bits_buf    (dirty_bits_buf),
        .states_buf        (states_buf),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_evict          (wr_evict),
        .wr_set            (wr_set),
        .wr_way            (wr_way),
        .wr_data_line      (wr_data_line),
        .wr_data_tag       (wr_data_tag),
        .wr_data_sharers   (wr_data_sharers),
        .wr_data_owner     (wr_data_owner),
        .wr_data_hprot     (wr_data_hprot),
        .wr_data_dirty_bit (wr_data_dirty_bit),
        .wr_data_state     (wr_data_state),
        .wr_data_evict_way (wr_data_evict_way),
        .wb_busy           (wb_busy),
        .wb_done           (wb_done)
    );

    task automatic fill_bufs();
        for (int w = 0; w < LLC_WAYS; w++) begin
            lines_buf[w]      = {$urandom, $urandom, $urandom, $urandom};
            tags_buf[w]       = llc_tag_t'($urandom);
            sharers_buf[w]    = sharers_t'($urandom);
            owners_buf[w]     = owner_t'($urandom);
            hprots_buf[w]     = hprot_t'($urandom);
            dirty_bits_buf[w] = 1'($urandom);
            states_buf[w]     = llc_state_t'($urandom);
        end
    endtask

    // mode 0: always ready; 1: ready one cycle in three; 2: random, never more than 3 low in a row
    task automatic fill_ready(input int mode);
        for (int i = 0; i < PAT_LEN; i++) begin
            case (mode)
                0:       ready_pat[i] = 1'b1;
                1:       ready_pat[i] = ((i % 3) == 0);
                default: ready_pat[i] = ((i % 4) == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
        end
        ready_pat[0] = 1'($urandom_range(0, 1));
    endtask

    task automatic run_wb(input llc_set_t s, input logic [LLC_WAYS-1:0] m, input logic eu,
                          input llc_way_t ew, input bit hold, input string tag);
        int                exp_way [$];
        bit                exp_ev  [$];
        int                done_c;
        int                c;
        logic [DATA_W-1:0] exp_data;
        logic [DATA_W-1:0] got_data;
        for (int w = 0; w < LLC_WAYS; w++) begin
            if (!SKIP || m[w]) begin
                exp_way.push_back(w);
                exp_ev.push_back(1'b0);
            end
        end
        if (eu) begin
            exp_way.push_back(0);
            exp_ev.push_back(1'b1);
        end
        c = 1;
        for (int b = 0; b < exp_way.size(); b++) begin
            while (!ready_pat[c] && c < PAT_LEN - 2) c++;
            c++;
        end
        done_c = c;

        fill_bufs();
        wb_set = s; wb_dirty_mask = m; wb_evict_upd = eu; evict_way_buf = ew;
        wb_start_valid = 1'b1;
        wr_ready = ready_pat[0];
        checks++;
        if (wb_start_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s start_ready cycle0 got=%b exp=1", tag, wb_start_ready);
        end
        @(posedge clk); @(negedge clk);
        for (int cy = 1; cy <= done_c; cy++) begin
            if (!hold) wb_start_valid = 1'b0;
            wr_ready = ready_pat[cy];
            checks++;
            if (wb_done !== 1'(cy == done_c)) begin
                failures++;
                $display("FAIL %s wb_done cycle%0d got=%b exp=%b", tag, cy, wb_done, cy == done_c);
            end
            checks++;
            if (wb_busy !== 1'(cy < done_c)) begin
                failures++;
                $display("FAIL %s wb_busy cycle%0d got=%b exp=%b", tag, cy, wb_busy, cy < done_c);
            end
            checks++;
            if (wb_start_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s start_ready busy cycle%0d got=%b exp=0", tag, cy, wb_start_ready);
            end
            checks++;
            if (wr_valid !== 1'(exp_way.size() != 0)) begin
                failures++;
                $display("FAIL %s wr_valid cycle%0d got=%b exp=%b", tag, cy, wr_valid, exp_way.size() != 0);
            end
            if (exp_way.size() != 0 && wr_valid === 1'b1) begin
                checks++;
                if (wr_evict !== exp_ev[0] || wr_set !== s) begin
                    failures++;
                    $display("FAIL %s evict/set cycle%0d got=%b/%h exp=%b/%h", tag, cy, wr_evict, wr_set, exp_ev[0], s);
                end
                if (exp_ev[0]) begin
                    checks++;
                    if (wr_way !== 4'd0 || wr_data_evict_way !== ew) begin
                        failures++;
                        $display("FAIL %s evict_beat cycle%0d got way=%0d ev=%0d exp way=0 ev=%0d", tag, cy, wr_way, wr_data_evict_way, ew);
                    end
                end else begin
                    exp_data = {lines_buf[exp_way[0]], tags_buf[exp_way[0]], sharers_buf[exp_way[0]], owners_buf[exp_way[0]],
                                hprots_buf[exp_way[0]], dirty_bits_buf[exp_way[0]], states_buf[exp_way[0]]};
                    got_data = {wr_data_line, wr_data_tag, wr_data_sharers, wr_data_owner,
                                wr_data_hprot, wr_data_dirty_bit, wr_data_state};
                    checks++;
                    if (wr_way !== llc_way_t'(exp_way[0])) begin
                        failures++;
                        $display("FAIL %s wr_way cycle%0d got=%0d exp=%0d", tag, cy, wr_way, exp_way[0]);
                    end
                    checks++;
                    if (got_data !== exp_data) begin
                        failures++;
                        $display("FAIL %s wr_data cycle%0d got=%h exp=%h", tag, cy, got_data, exp_data);
                    end
                end
                if (ready_pat[cy]) begin
                    void'(exp_way.pop_front());
                    void'(exp_ev.pop_front());
                end
            end
            @(posedge clk); @(negedge clk);
        end
        wr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (wb_start_ready !== 1'b1 || wr_valid !== 1'b0 || wb_busy !== 1'b0 || wb_done !== 1'b0) begin
            failures++;
            $display("FAIL reset ctrl got rdy=%b v=%b busy=%b done=%b exp 1/0/0/0", wb_start_ready, wr_valid, wb_busy, wb_done);
        end
        checks++;
        if (wr_evict !== 1'b0 || wr_set !== 9'd0 || wr_way !== 4'd0 || wr_data_line !== '0) begin
            failures++;
            $display("FAIL reset data got ev=%b set=%h way=%h exp zeros", wr_evict, wr_set, wr_way);
        end
    endtask

    task automatic test_full_evict();
        fill_ready(0);
        run_wb(9'h1A5, 16'hFFFF, 1'b1, 4'd7, 1'b0, "full_evict");
    endtask

    task automatic test_stall();
        fill_ready(1);
        run_wb(llc_set_t'($urandom), 16'($urandom), 1'b1, llc_way_t'($urandom), 1'b0, "stall_1of3");
    endtask

    task automatic test_sparse_mask();
        fill_ready(0);
        run_wb(llc_set_t'($urandom), 16'h8001, 1'b0, 4'd3, 1'b0, "mask_8001");
    endtask

    task automatic test_empty_mask();
        fill_ready(0);
        run_wb(9'h011, 16'h0000, 1'b0, 4'd2, 1'b0, "mask_zero");
        run_wb(9'h022, 16'h0010, 1'b1, 4'd9, 1'b0, "after_zero");
    endtask

    task automatic test_back_to_back();
        fill_ready(2);
        run_wb(9'h0F0, 16'($urandom), 1'b1, 4'd5, 1'b1, "held_first");
        run_wb(9'h10F, 16'($urandom), 1'b0, 4'd6, 1'b0, "held_second");
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            fill_ready(r % 3);
            run_wb(llc_set_t'($urandom), 16'($urandom), 1'($urandom), llc_way_t'($urandom), 1'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid_beat();
        fill_ready(0);
        fill_bufs();
        wb_set = 9'h055; wb_dirty_mask = 16'hFFFF; wb_evict_upd = 1'b1; evict_way_buf = 4'd1;
        wb_start_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        wb_start_valid = 1'b0;
        wr_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); @(negedge clk);
        end
        wr_ready = 1'b0;
        checks++;
        if (wr_valid !== 1'b1 || wr_way !== 4'd5) begin
            failures++;
            $display("FAIL rst_mid pre got v=%b way=%0d exp v=1 way=5", wr_valid, wr_way);
        end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        checks++;
        if (wr_valid !== 1'b0 || wb_busy !== 1'b0 || wb_start_ready !== 1'b1 || wb_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid post got v=%b busy=%b rdy=%b done=%b exp 0/0/1/0", wr_valid, wb_busy, wb_start_ready, wb_done);
        end
        wr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (wr_valid !== 1'b0 || wb_done !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid idle cycle%0d got v=%b done=%b exp 0/0", i, wr_valid, wb_done);
            end
        end
        wr_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wb_start_valid = 1'b0;
        wb_set = '0; wb_dirty_mask = '0; wb_evict_upd = 1'b0; evict_way_buf = '0;
        wr_ready = 1'b0;
        fill_bufs();
        test_reset();
        test_full_evict();
        test_stall();
        test_sparse_mask();
        test_empty_mask();
        test_back_to_back();
        test_random();
        test_reset_mid_beat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
